// File: rtl/lm32_tlb_maint_ctrl_pkg.sv
// Shared encodings and width helpers for the LM32 TLB maintenance sequencer.
package lm32_tlb_maint_ctrl_pkg;

    localparam int unsigned LM32_CSR_WIDTH = 5;
    localparam logic [LM32_CSR_WIDTH-1:0] CSR_TLB_PADDRESS = 5'h11;
    localparam logic [LM32_CSR_WIDTH-1:0] CSR_TLB_VADDRESS = 5'h12;

    localparam logic [4:0] TLB_OP_FLUSH_I    = 5'h01;
    localparam logic [4:0] TLB_OP_FLUSH_D    = 5'h02;
    localparam logic [4:0] TLB_OP_FLUSH_BOTH = 5'h03;
    localparam logic [4:0] TLB_OP_INVALIDATE = 5'h10;
    localparam logic [4:0] TLB_OP_CLR_OVF    = 5'h1F;

    // Target mask: bit0 = ITLB, bit1 = DTLB.
    localparam logic [1:0] TGT_I    = 2'b01;
    localparam logic [1:0] TGT_D    = 2'b10;
    localparam logic [1:0] TGT_BOTH = 2'b11;

    typedef enum logic [1:0] {
        CMD_UPDATE = 2'd0,
        CMD_INVAL  = 2'd1,
        CMD_FLUSH  = 2'd2
    } cmd_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } disp_state_e;

    function automatic int unsigned tlb_vw(input int unsigned page_size);
        return 32 - $clog2(page_size);
    endfunction

    function automatic int unsigned tlb_tw(input int unsigned page_size, input int unsigned tlb_sets);
        return tlb_vw(page_size) - $clog2(tlb_sets);
    endfunction

endpackage

// File: rtl/lm32_tlb_cmd_fifo.sv
// Two-entry synchronous command FIFO; a push while full is accepted only
// when a pop frees the head slot in the same cycle.
module lm32_tlb_cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [1:0]       count_o
);

    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == 2'd0);
    assign count_o   = count_q;
    assign dout_o    = mem_q[rd_ptr_q];
    assign pop_ok_s  = pop_i & ~empty_o;
    assign push_ok_s = push_i & (~full_o | pop_ok_s);

    always_comb begin
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_q ^ push_ok_s;
            rd_ptr_q <= rd_ptr_q ^ pop_ok_s;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/lm32_tlb_maint_ctrl.sv
// TLB maintenance sequencer: decodes TLB CSR writes into queued update,
// invalidate and flush commands and drives the ITLB/DTLB RAM write ports.
module lm32_tlb_maint_ctrl
    import lm32_tlb_maint_ctrl_pkg::*;
#(
    parameter int unsigned tlb_sets   = 1024,
    parameter int unsigned page_size  = 4096,
    parameter int unsigned fifo_depth = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [LM32_CSR_WIDTH-1:0] csr,
    input  logic [31:0]               csr_write_data,
    input  logic                      csr_write_enable,
    output logic                      itlb_we,
    output logic [$clog2(tlb_sets)-1:0] itlb_waddr,
    output logic [tlb_vw(page_size)+tlb_tw(page_size, tlb_sets):0] itlb_wdata,
    output logic                      dtlb_we,
    output logic [$clog2(tlb_sets)-1:0] dtlb_waddr,
    output logic [tlb_vw(page_size)+tlb_tw(page_size, tlb_sets):0] dtlb_wdata,
    output logic                      itlb_inhibit,
    output logic                      dtlb_inhibit,
    output logic                      busy,
    output logic [31:0]               csr_read_data
);

    localparam int unsigned OFS_W = $clog2(page_size);
    localparam int unsigned IW    = $clog2(tlb_sets);
    localparam int unsigned VW    = tlb_vw(page_size);
    localparam int unsigned TW    = tlb_tw(page_size, tlb_sets);
    localparam int unsigned DW    = 1 + TW + VW;
    localparam int unsigned EW    = 4 + IW + TW + VW;
    localparam logic [IW-1:0] LAST_SET = IW'(tlb_sets - 1);

    function automatic logic [EW-1:0] pack_cmd(input logic [1:0] op, input logic [1:0] tgt,
                                               input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                                               input logic [VW-1:0] pfn);
        return {op, tgt, idx, tag, pfn};
    endfunction

    logic [VW-1:0]   vaddr_q, vaddr_d;
    logic            ovf_q, ovf_d;
    disp_state_e     state_q, state_d;
    logic [IW-1:0]   set_cnt_q, set_cnt_d;
    logic [1:0]      sweep_tgt_q, sweep_tgt_d;

    logic            cmd_push_s;
    logic [EW-1:0]   cmd_entry_s;
    logic            clr_ovf_s;
    logic            pop_s;
    logic [EW-1:0]   head_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [1:0]      fifo_count_s;
    logic [1:0]      we_tgt_s;
    logic [IW-1:0]   waddr_s;
    logic [DW-1:0]   wdata_s;
    logic            sweep_s;
    logic            unused_s;

    logic [1:0]      head_op_s;
    logic [1:0]      head_tgt_s;
    logic [IW-1:0]   head_idx_s;
    logic [TW-1:0]   head_tag_s;
    logic [VW-1:0]   head_pfn_s;

    assign head_op_s  = head_s[EW-1 -: 2];
    assign head_tgt_s = head_s[EW-3 -: 2];
    assign head_idx_s = head_s[TW+VW +: IW];
    assign head_tag_s = head_s[VW +: TW];
    assign head_pfn_s = head_s[0 +: VW];
    assign unused_s   = ^csr_write_data;

    lm32_tlb_cmd_fifo #(
        .WIDTH (EW),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (cmd_push_s),
        .pop_i   (pop_s),
        .din_i   (cmd_entry_s),
        .dout_o  (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // CSR write decode: vaddr load, command enqueue and overflow clear.
    always_comb begin
        cmd_push_s  = 1'b0;
        cmd_entry_s = '0;
        clr_ovf_s   = 1'b0;
        vaddr_d     = vaddr_q;
        if (csr_write_enable && (csr == CSR_TLB_VADDRESS)) begin
            if (!csr_write_data[0]) begin
                vaddr_d = csr_write_data[31 -: VW];
            end else begin
                case (csr_write_data[5:1])
                    TLB_OP_FLUSH_I: begin
                        cmd_push_s  = 1'b1;
                        cmd_entry_s = pack_cmd(CMD_FLUSH, TGT_I, '0, '0, '0);
                    end
                    TLB_OP_FLUSH_D: begin
                        cmd_push_s  = 1'b1;
                        cmd_entry_s = pack_cmd(CMD_FLUSH, TGT_D, '0, '0, '0);
                    end
                    TLB_OP_FLUSH_BOTH: begin
                        cmd_push_s  = 1'b1;
                        cmd_entry_s = pack_cmd(CMD_FLUSH, TGT_BOTH, '0, '0, '0);
                    end
                    TLB_OP_INVALIDATE: begin
                        cmd_push_s  = 1'b1;
                        cmd_entry_s = pack_cmd(CMD_INVAL, csr_write_data[6] ? TGT_D : TGT_I,
                                               csr_write_data[OFS_W +: IW], '0, '0);
                    end
                    TLB_OP_CLR_OVF: clr_ovf_s = 1'b1;
                    default:        clr_ovf_s = 1'b0;
                endcase
            end
        end else if (csr_write_enable && (csr == CSR_TLB_PADDRESS) && !csr_write_data[0]) begin
            // Payload is snapshotted now so later vaddr writes cannot disturb it.
            cmd_push_s  = 1'b1;
            cmd_entry_s = pack_cmd(CMD_UPDATE, csr_write_data[1] ? TGT_D : TGT_I,
                                   vaddr_q[IW-1:0], vaddr_q[VW-1 -: TW], csr_write_data[31 -: VW]);
        end else begin
            cmd_push_s = 1'b0;
        end
    end

    // Sticky overflow: a push dropped because the FIFO is full and not draining.
    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf_s) begin
            ovf_d = 1'b0;
        end else if (cmd_push_s && fifo_full_s && !pop_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Dispatcher next state and RAM write-port drive.
    always_comb begin
        state_d     = state_q;
        set_cnt_d   = set_cnt_q;
        sweep_tgt_d = sweep_tgt_q;
        pop_s       = 1'b0;
        we_tgt_s    = 2'b00;
        waddr_s     = '0;
        wdata_s     = '0;
        sweep_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s = 1'b1;
                    case (head_op_s)
                        CMD_FLUSH: begin
                            state_d     = ST_SWEEP;
                            set_cnt_d   = LAST_SET;
                            sweep_tgt_d = head_tgt_s;
                        end
                        CMD_UPDATE: begin
                            we_tgt_s = head_tgt_s;
                            waddr_s  = head_idx_s;
                            wdata_s  = {1'b1, head_tag_s, head_pfn_s};
                        end
                        CMD_INVAL: begin
                            we_tgt_s = head_tgt_s;
                            waddr_s  = head_idx_s;
                        end
                        default: we_tgt_s = 2'b00;
                    endcase
                end else begin
                    pop_s = 1'b0;
                end
            end
            ST_SWEEP: begin
                we_tgt_s = sweep_tgt_q;
                waddr_s  = set_cnt_q;
                sweep_s  = 1'b1;
                if (set_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    set_cnt_d = set_cnt_q - IW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset launches a full sweep of both TLBs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vaddr_q     <= '0;
            ovf_q       <= 1'b0;
            state_q     <= ST_SWEEP;
            set_cnt_q   <= LAST_SET;
            sweep_tgt_q <= TGT_BOTH;
        end else begin
            vaddr_q     <= vaddr_d;
            ovf_q       <= ovf_d;
            state_q     <= state_d;
            set_cnt_q   <= set_cnt_d;
            sweep_tgt_q <= sweep_tgt_d;
        end
    end

    assign itlb_we       = we_tgt_s[0] & ~rst_i;
    assign dtlb_we       = we_tgt_s[1] & ~rst_i;
    assign itlb_waddr    = waddr_s;
    assign dtlb_waddr    = waddr_s;
    assign itlb_wdata    = wdata_s;
    assign dtlb_wdata    = wdata_s;
    assign itlb_inhibit  = itlb_we & sweep_s;
    assign dtlb_inhibit  = dtlb_we & sweep_s;
    assign busy          = (fifo_count_s != 2'd0) | (state_q == ST_SWEEP) | itlb_we | dtlb_we;
    assign csr_read_data = {28'd0, fifo_count_s, ovf_q, busy};

endmodule

// File: tb/tb_lm32_tlb_maint_ctrl.sv
// Directed, scoreboard-based bench for lm32_tlb_maint_ctrl with 16-entry TLBs.
module tb_lm32_tlb_maint_ctrl;
    import lm32_tlb_maint_ctrl_pkg::*;

    localparam int unsigned SETS = 16;
    localparam int unsigned PAGE = 4096;
    localparam int unsigned IW   = 4;
    localparam int unsigned DW   = 37;

    typedef struct packed {
        logic [IW-1:0] addr;
        logic [DW-1:0] data;
        logic          inh;
    } exp_t;

    logic                      clk_i = 1'b0;
    logic                      rst_i;
    logic [LM32_CSR_WIDTH-1:0] csr;
    logic [31:0]               csr_write_data;
    logic                      csr_write_enable;
    logic                      itlb_we, dtlb_we, itlb_inhibit, dtlb_inhibit, busy;
    logic [IW-1:0]             itlb_waddr, dtlb_waddr;
    logic [DW-1:0]             itlb_wdata, dtlb_wdata;
    logic [31:0]               csr_read_data;

    exp_t iq[$];
    exp_t dq[$];
    exp_t e_i, e_d;
    int   n_assert = 0;
    int   n_fail   = 0;

    lm32_tlb_maint_ctrl #(.tlb_sets(SETS), .page_size(PAGE), .fifo_depth(2)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .csr              (csr),
        .csr_write_data   (csr_write_data),
        .csr_write_enable (csr_write_enable),
        .itlb_we          (itlb_we),
        .itlb_waddr       (itlb_waddr),
        .itlb_wdata       (itlb_wdata),
        .dtlb_we          (dtlb_we),
        .dtlb_waddr       (dtlb_waddr),
        .dtlb_wdata       (dtlb_wdata),
        .itlb_inhibit     (itlb_inhibit),
        .dtlb_inhibit     (dtlb_inhibit),
        .busy             (busy),
        .csr_read_data    (csr_read_data)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int unsigned a, input logic [DW-1:0] d, input logic inh);
        exp_t r;
        r.addr = IW'(a);
        r.data = d;
        r.inh  = inh;
        return r;
    endfunction

    task automatic push_sweep(input bit to_i, input bit to_d, input int hi, input int lo);
        for (int a = hi; a >= lo; a--) begin
            if (to_i) iq.push_back(mk(a, '0, 1'b1));
            if (to_d) dq.push_back(mk(a, '0, 1'b1));
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic csr_wr(input logic [LM32_CSR_WIDTH-1:0] idx, input logic [31:0] d);
        csr              = idx;
        csr_write_data   = d;
        csr_write_enable = 1'b1;
        tick();
        csr_write_enable = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_iq_left"}, 64'(iq.size()), 64'd0);
        check({tag, "_dq_left"}, 64'(dq.size()), 64'd0);
    endtask

    // Write-port monitor: every RAM write must match the next expected entry.
    always @(negedge clk_i) begin
        if (rst_i) begin
            check("we_in_reset", 64'({itlb_we, dtlb_we}), 64'd0);
        end else begin
            if (itlb_we) begin
                if (iq.size() == 0) begin
                    check("itlb_spurious_we", 64'(itlb_we), 64'd0);
                end else begin
                    e_i = iq.pop_front();
                    check("itlb_write", 64'({itlb_waddr, itlb_wdata, itlb_inhibit}), 64'(e_i));
                end
            end else begin
                check("itlb_inhibit_idle", 64'(itlb_inhibit), 64'd0);
            end
            if (dtlb_we) begin
                if (dq.size() == 0) begin
                    check("dtlb_spurious_we", 64'(dtlb_we), 64'd0);
                end else begin
                    e_d = dq.pop_front();
                    check("dtlb_write", 64'({dtlb_waddr, dtlb_wdata, dtlb_inhibit}), 64'(e_d));
                end
            end else begin
                check("dtlb_inhibit_idle", 64'(dtlb_inhibit), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_i            = 1'b1;
        csr              = '0;
        csr_write_data   = '0;
        csr_write_enable = 1'b0;
        tick();
        tick();
        check("reset_status", 64'(csr_read_data), 64'h1);
        tick();

        // Reset release: full sweep of both TLBs, 16 cycles.
        push_sweep(1'b1, 1'b1, 15, 0);
        rst_i = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("reset_sweep_len", 64'(n), 64'd16);
        check("reset_iq_left", 64'(iq.size()), 64'd0);
        check("reset_dq_left", 64'(dq.size()), 64'd0);

        // UPDATE into ITLB with one-cycle latency.
        csr_wr(CSR_TLB_VADDRESS, 32'h0000_5000);
        iq.push_back(mk(5, {1'b1, 16'h0000, 20'h80003}, 1'b0));
        csr_wr(CSR_TLB_PADDRESS, 32'h8000_3000);
        check("upd_i_latency_itlb_we", 64'(itlb_we), 64'd1);
        check("upd_i_latency_dtlb_we", 64'(dtlb_we), 64'd0);
        drain("upd_i");

        // UPDATE into DTLB with non-zero tag.
        csr_wr(CSR_TLB_VADDRESS, 32'h1234_A000);
        dq.push_back(mk(10, {1'b1, 16'h1234, 20'h0ABCD}, 1'b0));
        csr_wr(CSR_TLB_PADDRESS, 32'h0ABC_D002);
        check("upd_d_latency_dtlb_we", 64'(dtlb_we), 64'd1);
        check("upd_d_latency_itlb_we", 64'(itlb_we), 64'd0);
        drain("upd_d");

        // Ignored writes: PADDR with bit0 set, undefined op.
        csr_wr(CSR_TLB_PADDRESS, 32'hFFFF_F001);
        csr_wr(CSR_TLB_VADDRESS, 32'h0000_000B);
        check("ignored_status", 64'(csr_read_data), 64'h0);

        // FLUSH_I with UPDATE and INVALIDATE queued behind it.
        push_sweep(1'b1, 1'b0, 15, 0);
        iq.push_back(mk(7, {1'b1, 16'h0000, 20'h11111}, 1'b0));
        iq.push_back(mk(3, '0, 1'b0));
        csr_wr(CSR_TLB_VADDRESS, 32'h0000_0003);
        csr_wr(CSR_TLB_VADDRESS, 32'h0000_7000);
        csr_wr(CSR_TLB_PADDRESS, 32'h1111_1000);
        csr_wr(CSR_TLB_VADDRESS, 32'h0000_3021);
        check("flush_i_count", 64'(csr_read_data[3:2]), 64'd2);
        check("flush_i_ovf", 64'(csr_read_data[1]), 64'd0);
        drain("flush_i");

        // FLUSH_D, fill the FIFO, overflow on the third command, then clear.
        push_sweep(1'b0, 1'b1, 15, 0);
        dq.push_back(mk(1, '0, 1'b0));
        dq.push_back(mk(2, '0, 1'b0));
        csr_wr(CSR_TLB_VADDRESS, 32'h0000_0005);
        csr_wr(CSR_TLB_VADDRESS, 32'h0000_1061);
        csr_wr(CSR_TLB_VADDRESS, 32'h0000_2061);
        check("pre_ovf_flag", 64'(csr_read_data[1]), 64'd0);
        csr_wr(CSR_TLB_VADDRESS, 32'h0000_4061);
        check("ovf_flag_set", 64'(csr_read_data[1]), 64'd1);
        check("ovf_count", 64'(csr_read_data[3:2]), 64'd2);
        csr_wr(CSR_TLB_VADDRESS, 32'h0000_003F);
        check("ovf_flag_cleared", 64'(csr_read_data[1]), 64'd0);
        drain("flush_d");

        // FLUSH_BOTH interrupted by reset at index 7; sweep restarts.
        push_sweep(1'b1, 1'b1, 15, 8);
        csr_wr(CSR_TLB_VADDRESS, 32'h0000_0007);
        csr_wr(CSR_TLB_VADDRESS, 32'h0000_5021);
        n = 0;
        while (!(itlb_we && itlb_waddr == 4'd7) && n < 50) begin
            tick();
            n++;
        end
        check("mid_sweep_addr", 64'(itlb_waddr), 64'd7);
        rst_i = 1'b1;
        #1;
        check("mid_reset_we", 64'({itlb_we, dtlb_we}), 64'd0);
        tick();
        check("mid_reset_status", 64'(csr_read_data), 64'h1);
        tick();
        push_sweep(1'b1, 1'b1, 15, 0);
        rst_i = 1'b0;
        #1;
        check("restart_top_addr", 64'(itlb_waddr), 64'd15);
        drain("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
